// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS core: opcodes, ALU op classes and
// the decoded control bundle carried down the pipeline.
package mips_pkg;

    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned FUNCT_W  = 6;
    localparam int unsigned ALUOP_W  = 2;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
    localparam logic [OPCODE_W-1:0] OP_ORI   = 6'b001101;

    typedef enum logic [ALUOP_W-1:0] {
        ALU_ADD = 2'b00,
        ALU_BR  = 2'b01,
        ALU_R   = 2'b10,
        ALU_I   = 2'b11
    } aluop_e;

    typedef struct packed {
        logic               regdst;
        logic               regwrite;
        logic               alusrc;
        logic [ALUOP_W-1:0] aluop;
        logic               memread;
        logic               memwrite;
        logic               memtoreg;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection between the load in EX and the instruction in ID.
// Flush wins over stall because the ID instruction is on the wrong path.
module hazard_detect
    import mips_pkg::*;
(
    input  logic             ex_memread_i,
    input  logic [REG_W-1:0] ex_rt_i,
    input  logic             ex_valid_i,
    input  logic [REG_W-1:0] rs_i,
    input  logic [REG_W-1:0] rt_i,
    input  logic             id_valid_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             bubble_o
);

    logic w_hz;

    // rt is compared even for instructions that do not read it (conservative)
    assign w_hz = ex_valid_i & ex_memread_i & (ex_rt_i != REG_W'(0)) & id_valid_i
                & ((ex_rt_i == rs_i) | (ex_rt_i == rt_i));

    assign stall_o  = w_hz & ~flush_i;
    assign bubble_o = flush_i | stall_o | ~id_valid_i;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, bubble insertion on stall,
// flush or empty ID, and a saturating stall-cycle counter.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 regdst_i,
    input  logic                 regwrite_i,
    input  logic                 alusrc_i,
    input  logic [ALUOP_W-1:0]   aluop_i,
    input  logic                 memread_i,
    input  logic                 memwrite_i,
    input  logic                 memtoreg_i,
    input  logic                 id_valid_i,
    input  logic [DATA_W-1:0]    rs_data_i,
    input  logic [DATA_W-1:0]    rt_data_i,
    input  logic [DATA_W-1:0]    imm_i,
    input  logic [REG_W-1:0]     rs_i,
    input  logic [REG_W-1:0]     rt_i,
    input  logic [REG_W-1:0]     rd_i,
    input  logic [FUNCT_W-1:0]   funct_i,
    input  logic                 flush_i,
    output logic                 ex_regdst_o,
    output logic                 ex_regwrite_o,
    output logic                 ex_alusrc_o,
    output logic [ALUOP_W-1:0]   ex_aluop_o,
    output logic                 ex_memread_o,
    output logic                 ex_memwrite_o,
    output logic                 ex_memtoreg_o,
    output logic [DATA_W-1:0]    ex_rs_data_o,
    output logic [DATA_W-1:0]    ex_rt_data_o,
    output logic [DATA_W-1:0]    ex_imm_o,
    output logic [REG_W-1:0]     ex_rs_o,
    output logic [REG_W-1:0]     ex_rt_o,
    output logic [REG_W-1:0]     ex_rd_o,
    output logic [FUNCT_W-1:0]   ex_funct_o,
    output logic                 ex_valid_o,
    output logic                 pc_write_o,
    output logic                 if_id_write_o,
    output logic [CNT_W-1:0]     stall_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    ctrl_t              r_ctrl;
    logic               r_valid;
    logic [DATA_W-1:0]  r_rs_data;
    logic [DATA_W-1:0]  r_rt_data;
    logic [DATA_W-1:0]  r_imm;
    logic [REG_W-1:0]   r_rs;
    logic [REG_W-1:0]   r_rt;
    logic [REG_W-1:0]   r_rd;
    logic [FUNCT_W-1:0] r_funct;
    logic [CNT_W-1:0]   r_stall_cnt;

    ctrl_t              w_ctrl_in;
    ctrl_t              w_ctrl_next;
    logic               w_stall;
    logic               w_bubble;

    hazard_detect u_hazard_detect (
        .ex_memread_i (r_ctrl.memread),
        .ex_rt_i      (r_rt),
        .ex_valid_i   (r_valid),
        .rs_i         (rs_i),
        .rt_i         (rt_i),
        .id_valid_i   (id_valid_i),
        .flush_i      (flush_i),
        .stall_o      (w_stall),
        .bubble_o     (w_bubble)
    );

    // regdst/memtoreg are don't-cares for stores/branches; only a real 1 passes
    always_comb begin
        w_ctrl_in          = CTRL_NOP;
        w_ctrl_in.regdst   = (regdst_i === 1'b1);
        w_ctrl_in.regwrite = regwrite_i;
        w_ctrl_in.alusrc   = alusrc_i;
        w_ctrl_in.aluop    = aluop_i;
        w_ctrl_in.memread  = memread_i;
        w_ctrl_in.memwrite = memwrite_i;
        w_ctrl_in.memtoreg = (memtoreg_i === 1'b1);
    end

    assign w_ctrl_next = w_bubble ? CTRL_NOP : w_ctrl_in;

    // Pipeline register: data/specifiers always load, control may be a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl    <= CTRL_NOP;
            r_valid   <= 1'b0;
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_imm     <= '0;
            r_rs      <= '0;
            r_rt      <= '0;
            r_rd      <= '0;
            r_funct   <= '0;
        end else begin
            r_ctrl    <= w_ctrl_next;
            r_valid   <= ~w_bubble;
            r_rs_data <= rs_data_i;
            r_rt_data <= rt_data_i;
            r_imm     <= imm_i;
            r_rs      <= rs_i;
            r_rt      <= rt_i;
            r_rd      <= rd_i;
            r_funct   <= funct_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign ex_regdst_o   = r_ctrl.regdst;
    assign ex_regwrite_o = r_ctrl.regwrite;
    assign ex_alusrc_o   = r_ctrl.alusrc;
    assign ex_aluop_o    = r_ctrl.aluop;
    assign ex_memread_o  = r_ctrl.memread;
    assign ex_memwrite_o = r_ctrl.memwrite;
    assign ex_memtoreg_o = r_ctrl.memtoreg;
    assign ex_rs_data_o  = r_rs_data;
    assign ex_rt_data_o  = r_rt_data;
    assign ex_imm_o      = r_imm;
    assign ex_rs_o       = r_rs;
    assign ex_rt_o       = r_rt;
    assign ex_rd_o       = r_rd;
    assign ex_funct_o    = r_funct;
    assign ex_valid_o    = r_valid;
    assign pc_write_o    = ~w_stall;
    assign if_id_write_o = ~w_stall;
    assign stall_cnt_o   = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: vector table for load-use/flush/bubble/counter
// behaviour plus hand-written reset sequences.
module tb_id_ex_stage;
    import mips_pkg::*;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 2;

    logic              clk;
    logic              rst_n;
    logic              regdst_i, regwrite_i, alusrc_i, memread_i, memwrite_i, memtoreg_i;
    logic [1:0]        aluop_i;
    logic              id_valid_i;
    logic [DATA_W-1:0] rs_data_i, rt_data_i, imm_i;
    logic [4:0]        rs_i, rt_i, rd_i;
    logic [5:0]        funct_i;
    logic              flush_i;
    logic              ex_regdst_o, ex_regwrite_o, ex_alusrc_o, ex_memread_o, ex_memwrite_o, ex_memtoreg_o;
    logic [1:0]        ex_aluop_o;
    logic [DATA_W-1:0] ex_rs_data_o, ex_rt_data_o, ex_imm_o;
    logic [4:0]        ex_rs_o, ex_rt_o, ex_rd_o;
    logic [5:0]        ex_funct_o;
    logic              ex_valid_o, pc_write_o, if_id_write_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    int checks;
    int failures;

    id_ex_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .regdst_i(regdst_i), .regwrite_i(regwrite_i), .alusrc_i(alusrc_i),
        .aluop_i(aluop_i), .memread_i(memread_i), .memwrite_i(memwrite_i),
        .memtoreg_i(memtoreg_i), .id_valid_i(id_valid_i),
        .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_i(imm_i),
        .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i), .funct_i(funct_i), .flush_i(flush_i),
        .ex_regdst_o(ex_regdst_o), .ex_regwrite_o(ex_regwrite_o), .ex_alusrc_o(ex_alusrc_o),
        .ex_aluop_o(ex_aluop_o), .ex_memread_o(ex_memread_o), .ex_memwrite_o(ex_memwrite_o),
        .ex_memtoreg_o(ex_memtoreg_o), .ex_rs_data_o(ex_rs_data_o), .ex_rt_data_o(ex_rt_data_o),
        .ex_imm_o(ex_imm_o), .ex_rs_o(ex_rs_o), .ex_rt_o(ex_rt_o), .ex_rd_o(ex_rd_o),
        .ex_funct_o(ex_funct_o), .ex_valid_o(ex_valid_o), .pc_write_o(pc_write_o),
        .if_id_write_o(if_id_write_o), .stall_cnt_o(stall_cnt_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        ctrl_t      ctrl;
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       flush;
        logic       exp_pcw;
        logic       exp_valid;
        ctrl_t      exp_ctrl;
        logic [1:0] exp_cnt;
    } vec_t;

    localparam ctrl_t C_LW  = '{regdst:1'b0, regwrite:1'b1, alusrc:1'b1, aluop:2'b00,
                                memread:1'b1, memwrite:1'b0, memtoreg:1'b1};
    localparam ctrl_t C_ADD = '{regdst:1'b1, regwrite:1'b1, alusrc:1'b0, aluop:2'b10,
                                memread:1'b0, memwrite:1'b0, memtoreg:1'b0};
    localparam ctrl_t C_SWE = '{regdst:1'b0, regwrite:1'b0, alusrc:1'b1, aluop:2'b00,
                                memread:1'b0, memwrite:1'b1, memtoreg:1'b0};

    vec_t vecs[22];

    function automatic vec_t mk(ctrl_t c, logic v, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                logic fl, logic pcw, logic ev, ctrl_t ec, logic [1:0] cnt);
        vec_t t;
        t.ctrl = c; t.valid = v; t.rs = rs; t.rt = rt; t.rd = rd; t.flush = fl;
        t.exp_pcw = pcw; t.exp_valid = ev; t.exp_ctrl = ec; t.exp_cnt = cnt;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input ctrl_t c, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic fl, input logic [31:0] tag);
        regdst_i = c.regdst; regwrite_i = c.regwrite; alusrc_i = c.alusrc; aluop_i = c.aluop;
        memread_i = c.memread; memwrite_i = c.memwrite; memtoreg_i = c.memtoreg;
        id_valid_i = v; rs_i = rs; rt_i = rt; rd_i = rd; flush_i = fl;
        rs_data_i = 32'hA000_0000 | tag; rt_data_i = 32'hB000_0000 | tag;
        imm_i = 32'hC000_0000 | tag; funct_i = 6'h20;
    endtask

    function automatic logic [7:0] ex_ctrl();
        return {ex_regdst_o, ex_regwrite_o, ex_alusrc_o, ex_aluop_o,
                ex_memread_o, ex_memwrite_o, ex_memtoreg_o};
    endfunction

    initial begin
        ctrl_t c_sw_x;
        checks = 0;
        failures = 0;
        c_sw_x = C_SWE;
        c_sw_x.regdst = 1'bx;
        c_sw_x.memtoreg = 1'bx;

        //                ctrl    v     rs     rt     rd     fl    pcw   ev    exp ctrl  cnt
        vecs[0]  = mk(C_LW,   1'b1, 5'd9,  5'd8,  5'd0,  1'b0, 1'b1, 1'b1, C_LW,     2'd0);
        vecs[1]  = mk(C_ADD,  1'b1, 5'd8,  5'd11, 5'd10, 1'b0, 1'b0, 1'b0, CTRL_NOP, 2'd1);
        vecs[2]  = mk(C_ADD,  1'b1, 5'd8,  5'd11, 5'd10, 1'b0, 1'b1, 1'b1, C_ADD,    2'd1);
        vecs[3]  = mk(C_LW,   1'b1, 5'd9,  5'd8,  5'd0,  1'b0, 1'b1, 1'b1, C_LW,     2'd1);
        vecs[4]  = mk(C_ADD,  1'b1, 5'd12, 5'd13, 5'd10, 1'b0, 1'b1, 1'b1, C_ADD,    2'd1);
        vecs[5]  = mk(C_LW,   1'b1, 5'd9,  5'd0,  5'd0,  1'b0, 1'b1, 1'b1, C_LW,     2'd1);
        vecs[6]  = mk(C_ADD,  1'b1, 5'd0,  5'd0,  5'd10, 1'b0, 1'b1, 1'b1, C_ADD,    2'd1);
        vecs[7]  = mk(C_LW,   1'b1, 5'd9,  5'd8,  5'd0,  1'b0, 1'b1, 1'b1, C_LW,     2'd1);
        vecs[8]  = mk(C_ADD,  1'b1, 5'd8,  5'd11, 5'd10, 1'b1, 1'b1, 1'b0, CTRL_NOP, 2'd1);
        vecs[9]  = mk(C_ADD,  1'b0, 5'd1,  5'd2,  5'd3,  1'b0, 1'b1, 1'b0, CTRL_NOP, 2'd1);
        vecs[10] = mk(C_LW,   1'b1, 5'd9,  5'd5,  5'd0,  1'b0, 1'b1, 1'b1, C_LW,     2'd1);
        vecs[11] = mk(c_sw_x, 1'b1, 5'd5,  5'd7,  5'd0,  1'b0, 1'b0, 1'b0, CTRL_NOP, 2'd2);
        vecs[12] = mk(c_sw_x, 1'b1, 5'd5,  5'd7,  5'd0,  1'b0, 1'b1, 1'b1, C_SWE,    2'd2);
        vecs[13] = mk(C_LW,   1'b1, 5'd9,  5'd5,  5'd0,  1'b0, 1'b1, 1'b1, C_LW,     2'd2);
        vecs[14] = mk(C_ADD,  1'b1, 5'd1,  5'd5,  5'd4,  1'b0, 1'b0, 1'b0, CTRL_NOP, 2'd3);
        vecs[15] = mk(C_ADD,  1'b1, 5'd1,  5'd5,  5'd4,  1'b0, 1'b1, 1'b1, C_ADD,    2'd3);
        vecs[16] = mk(C_LW,   1'b1, 5'd9,  5'd6,  5'd0,  1'b0, 1'b1, 1'b1, C_LW,     2'd3);
        vecs[17] = mk(C_ADD,  1'b1, 5'd6,  5'd2,  5'd4,  1'b0, 1'b0, 1'b0, CTRL_NOP, 2'd3);
        vecs[18] = mk(C_ADD,  1'b1, 5'd6,  5'd2,  5'd4,  1'b0, 1'b1, 1'b1, C_ADD,    2'd3);
        vecs[19] = mk(C_LW,   1'b1, 5'd9,  5'd7,  5'd0,  1'b0, 1'b1, 1'b1, C_LW,     2'd3);
        vecs[20] = mk(C_ADD,  1'b1, 5'd7,  5'd2,  5'd4,  1'b0, 1'b0, 1'b0, CTRL_NOP, 2'd3);
        vecs[21] = mk(C_ADD,  1'b1, 5'd7,  5'd2,  5'd4,  1'b0, 1'b1, 1'b1, C_ADD,    2'd3);

        rst_n = 1'b0;
        drive(CTRL_NOP, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0);
        #12;
        chk("reset_valid", 32'(ex_valid_o), 32'd0);
        chk("reset_ctrl", 32'(ex_ctrl()), 32'd0);
        chk("reset_cnt", 32'(stall_cnt_o), 32'd0);
        chk("reset_pcw", 32'(pc_write_o), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            drive(vecs[i].ctrl, vecs[i].valid, vecs[i].rs, vecs[i].rt, vecs[i].rd,
                  vecs[i].flush, 32'(i));
            #1;
            chk($sformatf("v%0d_pc_write", i), 32'(pc_write_o), 32'(vecs[i].exp_pcw));
            chk($sformatf("v%0d_if_id_write", i), 32'(if_id_write_o), 32'(vecs[i].exp_pcw));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_ex_valid", i), 32'(ex_valid_o), 32'(vecs[i].exp_valid));
            chk($sformatf("v%0d_ex_ctrl", i), 32'(ex_ctrl()), 32'(vecs[i].exp_ctrl));
            chk($sformatf("v%0d_ex_rt", i), 32'(ex_rt_o), 32'(vecs[i].rt));
            chk($sformatf("v%0d_ex_rd", i), 32'(ex_rd_o), 32'(vecs[i].rd));
            chk($sformatf("v%0d_ex_rs_data", i), ex_rs_data_o, 32'hA000_0000 | 32'(i));
            chk($sformatf("v%0d_ex_imm", i), ex_imm_o, 32'hC000_0000 | 32'(i));
            chk($sformatf("v%0d_stall_cnt", i), 32'(stall_cnt_o), 32'(vecs[i].exp_cnt));
        end

        // Async reset asserted while a stall is being raised
        drive(C_LW, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 32'd100);
        @(posedge clk);
        #1;
        drive(C_ADD, 1'b1, 5'd9, 5'd3, 5'd4, 1'b0, 32'd101);
        #1;
        chk("mid_stall_pcw", 32'(pc_write_o), 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(ex_valid_o), 32'd0);
        chk("rst_mid_ctrl", 32'(ex_ctrl()), 32'd0);
        chk("rst_mid_rt", 32'(ex_rt_o), 32'd0);
        chk("rst_mid_cnt", 32'(stall_cnt_o), 32'd0);
        chk("rst_mid_pcw", 32'(pc_write_o), 32'd1);
        chk("rst_mid_ifid", 32'(if_id_write_o), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_valid", 32'(ex_valid_o), 32'd1);
        chk("post_rst_ctrl", 32'(ex_ctrl()), 32'(C_ADD));
        chk("post_rst_rd", 32'(ex_rd_o), 32'd4);
        chk("post_rst_cnt", 32'(stall_cnt_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
